// File: rtl/pll_lock_monitor_if.sv
// Bundles the lock input, the clear strobe and the reset/status outputs of the PLL lock monitor.
// master = the side driving pll_lock/clear_lost, slave = the monitor itself.
interface pll_lock_monitor_if #(
    parameter int COUNT_WIDTH = 8
);
    logic                   pll_lock;
    logic                   clear_lost;
    logic                   sys_rst;
    logic                   ready;
    logic                   lock_lost;
    logic [COUNT_WIDTH-1:0] lost_count;

    modport master (
        output pll_lock,
        output clear_lost,
        input  sys_rst,
        input  ready,
        input  lock_lost,
        input  lost_count
    );

    modport slave (
        input  pll_lock,
        input  clear_lost,
        output sys_rst,
        output ready,
        output lock_lost,
        output lost_count
    );
endinterface

// File: rtl/pll_lock_monitor.sv
// Holds downstream logic in reset until the synchronised PLL lock has been stable for
// STABLE_CYCLES cycles, and records sticky loss-of-lock events seen while running.
module pll_lock_monitor #(
    parameter int STABLE_CYCLES = 1024,
    parameter int SYNC_STAGES   = 2,
    parameter int COUNT_WIDTH   = 8
) (
    input  logic                clk,
    input  logic                rst,
    pll_lock_monitor_if.slave   bus
);

    localparam int                CNT_W    = $clog2(STABLE_CYCLES);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        COUNT     = 2'd1,
        RUN       = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [SYNC_STAGES-1:0]  sync_q, sync_d;
    logic                    sys_rst_q, sys_rst_d;
    logic                    ready_q, ready_d;
    logic                    lock_lost_q, lock_lost_d;
    logic [COUNT_WIDTH-1:0]  lost_count_q, lost_count_d;
    logic                    lock_s;
    logic                    loss_s;

    function automatic logic [COUNT_WIDTH-1:0] sat_inc(input logic [COUNT_WIDTH-1:0] v);
        if (&v) begin
            return v;
        end else begin
            return v + COUNT_WIDTH'(1);
        end
    endfunction

    assign lock_s = sync_q[SYNC_STAGES-1];

    // Synchroniser shift, qualification FSM next state and registered output decode.
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], bus.pll_lock};
        state_d = state_q;
        cnt_d   = cnt_q;
        loss_s  = 1'b0;
        case (state_q)
            WAIT_LOCK: begin
                if (lock_s) begin
                    state_d = COUNT;
                    cnt_d   = {CNT_W{1'b0}};
                end else begin
                    state_d = WAIT_LOCK;
                    cnt_d   = {CNT_W{1'b0}};
                end
            end
            COUNT: begin
                if (!lock_s) begin
                    state_d = WAIT_LOCK;
                    cnt_d   = {CNT_W{1'b0}};
                end else if (cnt_q == CNT_LAST) begin
                    state_d = RUN;
                    cnt_d   = {CNT_W{1'b0}};
                end else begin
                    state_d = COUNT;
                    cnt_d   = cnt_q + CNT_W'(1);
                end
            end
            RUN: begin
                if (!lock_s) begin
                    state_d = WAIT_LOCK;
                    cnt_d   = {CNT_W{1'b0}};
                    loss_s  = 1'b1;
                end else begin
                    state_d = RUN;
                    cnt_d   = {CNT_W{1'b0}};
                end
            end
            default: begin
                state_d = WAIT_LOCK;
                cnt_d   = {CNT_W{1'b0}};
            end
        endcase

        sys_rst_d = (state_d != RUN);
        ready_d   = (state_d == RUN);

        // A clear on the same edge as a loss is applied first so the new loss survives.
        if (bus.clear_lost) begin
            lock_lost_d  = 1'b0;
            lost_count_d = {COUNT_WIDTH{1'b0}};
        end else begin
            lock_lost_d  = lock_lost_q;
            lost_count_d = lost_count_q;
        end
        if (loss_s) begin
            lock_lost_d  = 1'b1;
            lost_count_d = sat_inc(lost_count_d);
        end else begin
            lock_lost_d  = lock_lost_d;
            lost_count_d = lost_count_d;
        end
    end

    // All state of the monitor, cleared asynchronously by rst.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= WAIT_LOCK;
            cnt_q        <= {CNT_W{1'b0}};
            sync_q       <= {SYNC_STAGES{1'b0}};
            sys_rst_q    <= 1'b1;
            ready_q      <= 1'b0;
            lock_lost_q  <= 1'b0;
            lost_count_q <= {COUNT_WIDTH{1'b0}};
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            sync_q       <= sync_d;
            sys_rst_q    <= sys_rst_d;
            ready_q      <= ready_d;
            lock_lost_q  <= lock_lost_d;
            lost_count_q <= lost_count_d;
        end
    end

    assign bus.sys_rst    = sys_rst_q;
    assign bus.ready      = ready_q;
    assign bus.lock_lost  = lock_lost_q;
    assign bus.lost_count = lost_count_q;

endmodule

// File: tb/tb_pll_lock_monitor.sv
// Directed and randomised checks of pll_lock_monitor against a streak-based reference model.
module tb_pll_lock_monitor;

    localparam int STABLE = 4;
    localparam int SYNC   = 2;
    localparam int CW     = 2;
    localparam int CMAX   = (1 << CW) - 1;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    // Model: lock_s history, streak of consecutive high lock_s edges, loss bookkeeping.
    bit   m_hist[$];
    int   m_streak;
    bit   m_run;
    bit   m_lost;
    int   m_cnt;

    pll_lock_monitor_if #(.COUNT_WIDTH(CW)) bus ();

    pll_lock_monitor #(
        .STABLE_CYCLES (STABLE),
        .SYNC_STAGES   (SYNC),
        .COUNT_WIDTH   (CW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_hist.delete();
        for (int i = 0; i < SYNC; i++) m_hist.push_back(1'b0);
        m_streak = 0;
        m_run    = 1'b0;
        m_lost   = 1'b0;
        m_cnt    = 0;
    endtask

    // Running requires lock_s high on STABLE+1 consecutive edges; any low edge breaks the streak.
    task automatic model_edge(input bit lk, input bit clr);
        bit pre;
        bit loss;
        pre = m_hist.pop_front();
        m_hist.push_back(lk);
        loss = m_run && !pre;
        m_streak = pre ? ((m_streak > STABLE) ? STABLE + 1 : m_streak + 1) : 0;
        m_run = (m_streak >= STABLE + 1);
        if (clr) begin
            m_lost = 1'b0;
            m_cnt  = 0;
        end
        if (loss) begin
            m_lost = 1'b1;
            if (m_cnt < CMAX) m_cnt++;
        end
    endtask

    task automatic check_model(input string tag);
        chk({tag, ".sys_rst"},    8'(bus.sys_rst),    8'(!m_run));
        chk({tag, ".ready"},      8'(bus.ready),      8'(m_run));
        chk({tag, ".lock_lost"},  8'(bus.lock_lost),  8'(m_lost));
        chk({tag, ".lost_count"}, 8'(bus.lost_count), 8'(m_cnt));
    endtask

    task automatic step(input bit lk, input bit clr);
        bus.pll_lock   = lk;
        bus.clear_lost = clr;
        @(posedge clk);
        model_edge(lk, clr);
        #1;
        check_model("step");
    endtask

    // Sub-cycle pulse on pll_lock that never straddles a clock edge.
    task automatic glitch_step(input bit lk);
        bus.pll_lock   = lk;
        bus.clear_lost = 1'b0;
        #2 bus.pll_lock = ~lk;
        #2 bus.pll_lock = lk;
        @(posedge clk);
        model_edge(lk, 1'b0);
        #1;
        check_model("glitch");
    endtask

    task automatic async_reset();
        bus.clear_lost = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("arst.sys_rst",    8'(bus.sys_rst),    8'd1);
        chk("arst.ready",      8'(bus.ready),      8'd0);
        chk("arst.lock_lost",  8'(bus.lock_lost),  8'd0);
        chk("arst.lost_count", 8'(bus.lost_count), 8'd0);
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        bit lk;
        bit clr;
        int r;
        n_checks = 0;
        n_fail   = 0;
        rst = 1'b1;
        bus.pll_lock   = 1'b0;
        bus.clear_lost = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_model("reset");
        rst = 1'b0;

        // Lock tied high from edge 1: release at edge 7.
        for (int e = 1; e <= 10; e++) begin
            step(1'b1, 1'b0);
            chk("r027.sys_rst", 8'(bus.sys_rst), (e < 7) ? 8'd1 : 8'd0);
            chk("r027.ready",   8'(bus.ready),   (e < 7) ? 8'd0 : 8'd1);
        end

        // Three-edge drop from RUN, then re-lock.
        for (int d = 1; d <= 3; d++) begin
            step(1'b0, 1'b0);
            chk("r029.sys_rst", 8'(bus.sys_rst), (d == 3) ? 8'd1 : 8'd0);
        end
        chk("r029.lock_lost",  8'(bus.lock_lost),  8'd1);
        chk("r029.lost_count", 8'(bus.lost_count), 8'd1);
        for (int j = 1; j <= 8; j++) step(1'b1, 1'b0);
        chk("r029.relock_ready", 8'(bus.ready),     8'd1);
        chk("r029.still_lost",   8'(bus.lock_lost), 8'd1);

        // Four losses saturate a 2-bit counter.
        step(1'b1, 1'b1);
        chk("r030.pre_clear", 8'(bus.lost_count), 8'd0);
        for (int k = 0; k < 4; k++) begin
            repeat (3) step(1'b0, 1'b0);
            chk("r030.lost_count", 8'(bus.lost_count), (k < 3) ? 8'(k + 1) : 8'd3);
            repeat (8) step(1'b1, 1'b0);
        end

        // Clear coincident with a loss edge.
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b1);
        chk("r031.lock_lost",  8'(bus.lock_lost),  8'd1);
        chk("r031.lost_count", 8'(bus.lost_count), 8'd1);
        repeat (8) step(1'b1, 1'b0);
        step(1'b1, 1'b1);
        chk("r030.clear_count", 8'(bus.lost_count), 8'd0);
        chk("r030.clear_flag",  8'(bus.lock_lost),  8'd0);

        // Short high burst, one low, then restart from zero.
        async_reset();
        repeat (4) step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        for (int j = 1; j <= 8; j++) begin
            step(1'b1, 1'b0);
            chk("r028.sys_rst", 8'(bus.sys_rst), (j < 7) ? 8'd1 : 8'd0);
        end
        chk("r028.lost_count", 8'(bus.lost_count), 8'd0);

        // Glitches in RUN must not drop out.
        repeat (3) glitch_step(1'b1);
        chk("r023.ready", 8'(bus.ready), 8'd1);

        // Async abort mid-RUN and mid-COUNT.
        async_reset();
        repeat (4) step(1'b1, 1'b0);
        async_reset();
        step(1'b0, 1'b0);

        lk = 1'b0;
        for (int i = 0; i < 1500; i++) begin
            r = $urandom_range(0, 99);
            if (r < 1) begin
                async_reset();
            end else if (r < 4) begin
                glitch_step(lk);
            end else begin
                if ($urandom_range(0, 11) == 0) lk = ~lk;
                clr = ($urandom_range(0, 19) == 0);
                step(lk, clr);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
